// File: rtl/mux_arb_reg.sv
`default_nettype none
// ============================================================================
// Module   : mux_arb_reg
// Brief    : Registered N-way selector with valid/ready handshakes. It either
//            arbitrates among requesters or forces one channel. A single
//            output register stage provides backpressure.
//            Define MUX_ARB_RR_EN for round-robin arbitration. When it is
//            undefined, arbitration is fixed priority (lowest index wins).
// Revision : 1.0 - initial release
// ============================================================================
module mux_arb_reg #(
    parameter int WIDTH = 32,
    parameter int N     = 16,
    parameter int SW    = $clog2(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    input  logic               force_sel,
    input  logic [SW-1:0]      sel,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SW-1:0]      out_sel,
    input  logic               out_ready
);

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_data;
    logic [SW-1:0]    r_sel;

    logic [SW-1:0]    w_ptr;
    logic [N-1:0]     w_sel_mask;
    logic [N-1:0]     w_hi_mask;
    logic [N-1:0]     w_elig;
    logic [N-1:0]     w_hi;
    logic [N-1:0]     w_pool;
    logic             w_load_en;
    logic             w_any;
    logic             w_accept;
    logic [SW-1:0]    w_grant;
    logic [WIDTH-1:0] w_gdata;

    // An out-of-range sel matches no channel, so forcing it leaves nothing eligible.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_masks
            assign w_sel_mask[gi] = (sel == SW'(gi));
            assign w_hi_mask[gi]  = (SW'(gi) >= w_ptr);
            assign in_ready[gi]   = w_accept && (w_grant == SW'(gi));
        end
    endgenerate

    assign w_elig    = force_sel ? (in_valid & w_sel_mask) : in_valid;
    assign w_any     = |w_elig;
    assign w_load_en = (r_state == S_EMPTY) || out_ready;
    assign w_accept  = !reset && w_load_en && w_any;

    // Channels at or above ptr take precedence; otherwise wrap to the lowest.
    assign w_hi   = w_elig & w_hi_mask;
    assign w_pool = (|w_hi) ? w_hi : w_elig;

    always_comb begin
        w_grant = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_pool[i]) begin
                w_grant = SW'(i);
            end
        end
    end

    always_comb begin
        w_gdata = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant == SW'(i)) begin
                w_gdata = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

`ifdef MUX_ARB_RR_EN
    logic [SW-1:0] r_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_accept && !force_sel) begin
            r_ptr <= (w_grant == SW'(N - 1)) ? '0 : w_grant + SW'(1);
        end
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_EMPTY;
            r_data  <= '0;
            r_sel   <= '0;
        end else if (w_load_en) begin
            if (w_any) begin
                r_state <= S_FULL;
                r_data  <= w_gdata;
                r_sel   <= w_grant;
            end else begin
                r_state <= S_EMPTY;
            end
        end
    end

    assign out_valid = (r_state == S_FULL);
    assign out_data  = r_data;
    assign out_sel   = r_sel;

endmodule
`default_nettype wire

// File: tb/tb_mux_arb_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_arb_reg
// Brief    : Self-checking bench for mux_arb_reg (N=16 and N=5 instances),
//            compared against a scan-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_arb_reg;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [15:0]   in_valid = '0;
    logic [511:0]  in_data = '0;
    logic [15:0]   in_ready;
    logic          force_sel = 1'b0;
    logic [3:0]    sel = '0;
    logic          out_valid;
    logic [31:0]   out_data;
    logic [3:0]    out_sel;
    logic          out_ready = 1'b0;

    logic          reset5 = 1'b1;
    logic [4:0]    in_valid5 = '0;
    logic [39:0]   in_data5 = '0;
    logic [4:0]    in_ready5;
    logic          force5 = 1'b0;
    logic [2:0]    sel5 = '0;
    logic          out_valid5;
    logic [7:0]    out_data5;
    logic [2:0]    out_sel5;
    logic          out_ready5 = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mux_arb_reg #(.WIDTH(32), .N(16)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .force_sel(force_sel), .sel(sel),
        .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
        .out_ready(out_ready)
    );

    mux_arb_reg #(.WIDTH(8), .N(5)) u_dut5 (
        .clk(clk), .reset(reset5), .in_valid(in_valid5), .in_data(in_data5),
        .in_ready(in_ready5), .force_sel(force5), .sel(sel5),
        .out_valid(out_valid5), .out_data(out_data5), .out_sel(out_sel5),
        .out_ready(out_ready5)
    );

    // Reference model for the N=16 instance
    logic        m_valid;
    logic [31:0] m_data;
    logic [3:0]  m_sel;
    int          m_ptr;
    int          exp_g;
    logic [15:0] exp_rdy;

    function automatic int exp_grant(input logic [15:0] v, input logic f,
                                     input logic [3:0] s, input int p);
        logic [15:0] e;
        e = f ? (v & (16'h1 << s)) : v;
        for (int k = 0; k < 16; k++) begin
            if (e[(p + k) % 16]) return (p + k) % 16;
        end
        return -1;
    endfunction

    always_comb begin
        exp_g   = exp_grant(in_valid, force_sel, sel, m_ptr);
        exp_rdy = '0;
        if (!reset && (!m_valid || out_ready) && exp_g >= 0) exp_rdy[exp_g] = 1'b1;
    end

    always @(posedge clk) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_sel   <= '0;
            m_ptr   <= 0;
        end else if (!m_valid || out_ready) begin
            if (exp_g >= 0) begin
                m_valid <= 1'b1;
                m_data  <= in_data[exp_g*32 +: 32];
                m_sel   <= 4'(exp_g);
`ifdef MUX_ARB_RR_EN
                if (!force_sel) m_ptr <= (exp_g + 1) % 16;
`endif
            end else begin
                m_valid <= 1'b0;
            end
        end
    end

    task automatic test_reset();
        for (int i = 0; i < 16; i++) in_data[i*32 +: 32] = 32'hA000_0000 + 32'(i);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            reset = 1'b1; in_valid = 16'hFFFF; out_ready = 1'b1;
            #1;
            n_checks++;
            if (in_ready !== 16'h0) begin
                n_fail++; $display("FAIL reset_in_ready got=%h exp=0", in_ready);
            end
            @(posedge clk); #1;
            n_checks++;
            if ({out_valid, out_data, out_sel} !== 37'h0) begin
                n_fail++; $display("FAIL reset_outputs got v=%b d=%h s=%0d exp all zero", out_valid, out_data, out_sel);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 16'h0001) begin
            n_fail++; $display("FAIL reset_first_ready got=%h exp=0001", in_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_sel !== 4'd0 || out_data !== 32'hA000_0000) begin
            n_fail++; $display("FAIL reset_first_accept got v=%b s=%0d d=%h exp v=1 s=0 d=a0000000", out_valid, out_sel, out_data);
        end
    endtask

    task automatic test_pattern();
        int seq [3];
        int e;
        seq[0] = 3; seq[1] = 7; seq[2] = 15;
        @(negedge clk); reset = 1'b1; @(negedge clk); reset = 1'b0;
        in_valid = 16'h8088; out_ready = 1'b1; force_sel = 1'b0;
        for (int c = 0; c < 9; c++) begin
            if (c > 0) @(negedge clk);
`ifdef MUX_ARB_RR_EN
            e = seq[c % 3];
`else
            e = 3;
`endif
            #1;
            n_checks++;
            if (in_ready !== (16'h1 << e)) begin
                n_fail++; $display("FAIL pattern_ready c=%0d got=%h exp=%h", c, in_ready, 16'h1 << e);
            end
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b1 || out_sel !== 4'(e) || out_data !== 32'hA000_0000 + 32'(e)) begin
                n_fail++; $display("FAIL pattern_out c=%0d got s=%0d d=%h exp s=%0d", c, out_sel, out_data, e);
            end
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk); reset = 1'b1; @(negedge clk); reset = 1'b0;
        in_data[5*32 +: 32] = 32'h1234_5678;
        in_data[9*32 +: 32] = 32'hCAFE_0009;
        in_valid = 16'h1 << 5; out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (out_sel !== 4'd5 || out_data !== 32'h1234_5678) begin
            n_fail++; $display("FAIL bp_load got s=%0d d=%h exp s=5 d=12345678", out_sel, out_data);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            in_valid = 16'h1 << 9; out_ready = 1'b0;
            #1;
            n_checks++;
            if (in_ready !== 16'h0) begin
                n_fail++; $display("FAIL bp_ready c=%0d got=%h exp=0", c, in_ready);
            end
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b1 || out_sel !== 4'd5 || out_data !== 32'h1234_5678) begin
                n_fail++; $display("FAIL bp_hold c=%0d got v=%b s=%0d d=%h exp v=1 s=5 d=12345678", c, out_valid, out_sel, out_data);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 16'h0200) begin
            n_fail++; $display("FAIL bp_release_ready got=%h exp=0200", in_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_sel !== 4'd9 || out_data !== 32'hCAFE_0009) begin
            n_fail++; $display("FAIL bp_release_out got s=%0d d=%h exp s=9 d=cafe0009", out_sel, out_data);
        end
    endtask

    task automatic test_forced();
        int e;
        @(negedge clk); reset = 1'b1; @(negedge clk); reset = 1'b0;
        for (int i = 0; i < 16; i++) in_data[i*32 +: 32] = 32'hA000_0000 + 32'(i);
        in_valid = 16'h1 << 10; out_ready = 1'b1;
        @(negedge clk);
        force_sel = 1'b1; sel = 4'd12; in_valid = 16'h1001;
        #1;
        n_checks++;
        if (in_ready !== 16'h1000) begin
            n_fail++; $display("FAIL forced_ready got=%h exp=1000", in_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_sel !== 4'd12) begin
            n_fail++; $display("FAIL forced_out got v=%b s=%0d exp v=1 s=12", out_valid, out_sel);
        end
        @(negedge clk);
        in_valid = 16'h0001;
        #1;
        n_checks++;
        if (in_ready !== 16'h0) begin
            n_fail++; $display("FAIL forced_idle_ready got=%h exp=0", in_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_sel !== 4'd12) begin
            n_fail++; $display("FAIL forced_drain got v=%b s=%0d exp v=0 s=12", out_valid, out_sel);
        end
        // Pointer must still sit just past channel 10, untouched by the forced accept
        @(negedge clk);
        force_sel = 1'b0; in_valid = 16'h1001;
`ifdef MUX_ARB_RR_EN
        e = 12;
`else
        e = 0;
`endif
        @(posedge clk); #1;
        n_checks++;
        if (out_sel !== 4'(e)) begin
            n_fail++; $display("FAIL forced_ptr_kept got s=%0d exp s=%0d", out_sel, e);
        end
    endtask

    task automatic test_random();
        @(negedge clk); reset = 1'b1; @(negedge clk); reset = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (c > 0) @(negedge clk);
            in_valid  = 16'($urandom);
            force_sel = ($urandom_range(0, 3) == 0);
            sel       = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 16; i++) in_data[i*32 +: 32] = $urandom;
            #1;
            n_checks++;
            if (in_ready !== exp_rdy) begin
                n_fail++; $display("FAIL random_ready c=%0d got=%h exp=%h", c, in_ready, exp_rdy);
            end
            @(posedge clk); #1;
            n_checks++;
            if ({out_valid, out_data, out_sel} !== {m_valid, m_data, m_sel}) begin
                n_fail++; $display("FAIL random_out c=%0d got v=%b d=%h s=%0d exp v=%b d=%h s=%0d",
                                   c, out_valid, out_data, out_sel, m_valid, m_data, m_sel);
            end
        end
        out_ready = 1'b1; in_valid = '0; force_sel = 1'b0;
    endtask

    task automatic test_np2();
        int e;
        for (int i = 0; i < 5; i++) in_data5[i*8 +: 8] = 8'h50 + 8'(i);
        @(negedge clk); reset5 = 1'b1; @(negedge clk); reset5 = 1'b0;
        force5 = 1'b1; sel5 = 3'd6; in_valid5 = 5'h1F; out_ready5 = 1'b1;
        for (int c = 0; c < 2; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            n_checks++;
            if (in_ready5 !== 5'h0) begin
                n_fail++; $display("FAIL np2_bad_sel_ready c=%0d got=%h exp=0", c, in_ready5);
            end
            @(posedge clk); #1;
            n_checks++;
            if (out_valid5 !== 1'b0) begin
                n_fail++; $display("FAIL np2_bad_sel_valid c=%0d got=%b exp=0", c, out_valid5);
            end
        end
        @(negedge clk);
        force5 = 1'b0; in_valid5 = 5'b10001;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge clk);
`ifdef MUX_ARB_RR_EN
            e = (c % 2 == 0) ? 0 : 4;
`else
            e = 0;
`endif
            #1;
            n_checks++;
            if (in_ready5 !== (5'h1 << e)) begin
                n_fail++; $display("FAIL np2_wrap_ready c=%0d got=%h exp=%h", c, in_ready5, 5'h1 << e);
            end
            @(posedge clk); #1;
            n_checks++;
            if (out_valid5 !== 1'b1 || out_sel5 !== 3'(e) || out_data5 !== 8'h50 + 8'(e)) begin
                n_fail++; $display("FAIL np2_wrap_out c=%0d got s=%0d d=%h exp s=%0d", c, out_sel5, out_data5, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_pattern();
        test_backpressure();
        test_forced();
        test_random();
        test_np2();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
